axicb_slv_switch_rd: RTL and testbench
======================================

AXICB_SLV_SWITCH_RD -- requirements
Module: axicb_slv_switch_rd

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 16: AXI address width in bits.
REQ-002 SHALL have parameter AXI_ID_W, default 8: AXI ID width in bits.
REQ-003 SHALL have parameter AXI_DATA_W, default 8: AXI data width in bits.
REQ-004 SHALL have parameter SLV_NB, default 4, legal range 1..4: number of slaves.
REQ-005 SHALL have parameters SLVk_START_ADDR and SLVk_END_ADDR for k=0..3, each AXI_ADDR_W bits wide: inclusive address window of slave k. Defaults: k*0x1000 and k*0x1000+0xFFF.
REQ-006 SHALL have parameter ARCH_W, default AXI_ID_W+AXI_ADDR_W+8.
- Layout: ID at [0+:AXI_ID_W], ADDR at [AXI_ID_W+:AXI_ADDR_W], LEN at [AXI_ID_W+AXI_ADDR_W+:8].
- Bits above LEN are opaque.
REQ-007 SHALL have parameter RCH_W, default AXI_ID_W+AXI_DATA_W+2.
- Layout: ID at [0+:AXI_ID_W], DATA above ID, RESP[1:0] at the MSBs.
REQ-008 Ports, in this order (name, direction, width, meaning):
- aclk  in  1  clock; all logic on its rising edge.
- aresetn  in  1  synchronous active-low reset.
- i_arvalid  in  1  AR valid from the master side.
- i_arready  out  1  AR ready to the master side.
- i_arch  in  ARCH_W  AR payload.
- i_rvalid  out  1  R valid.
- i_rready  in  1  R ready.
- i_rlast  out  1  R last.
- i_rch  out  RCH_W  R payload.
- o_arvalid  out  SLV_NB  per-slave AR valid.
- o_arready  in  SLV_NB  per-slave AR ready.
- o_arch  out  ARCH_W  AR payload to the slaves.
- o_rvalid  in  SLV_NB  per-slave R valid.
- o_rready  out  SLV_NB  per-slave R ready.
- o_rlast  in  SLV_NB  per-slave R last.
- o_rch  in  SLV_NB*RCH_W  per-slave R payloads.

Function
REQ-009 Address decode SHALL be combinational.
- Slave k matches when SLVk_START_ADDR <= ADDR <= SLVk_END_ADDR.
- If several slaves match, the lowest index wins.
- If no slave matches, the request is unmapped.
REQ-010 o_arch SHALL equal i_arch unmodified.
REQ-011 For a mapped request to slave k:
- o_arvalid[k] = i_arvalid; all other o_arvalid bits SHALL be 0.
- i_arready = o_arready[k].
REQ-012 For an unmapped request:
- All o_arvalid bits SHALL be 0.
- i_arready = 1 only while the error generator is in ERR_IDLE.
REQ-013 Error generator FSM, states ERR_IDLE and ERR_RESP.
- ERR_IDLE -> ERR_RESP on an unmapped AR handshake; capture ID and LEN, and load the beat counter with LEN.
- In ERR_RESP it is R requester index SLV_NB and presents: valid=1, DATA=0, RESP=2'b11, ID=captured ID, rlast=(counter==0).
- Each R handshake of its beats decrements the counter.
- Handshake with counter==0 -> ERR_IDLE.
REQ-014 The R arbiter SHALL arbitrate among SLV_NB+1 requesters: the slaves, plus the error generator at index SLV_NB.
- Selection is round-robin, starting the search at the pointer and wrapping modulo SLV_NB+1.
REQ-015 R arbiter FSM, states R_IDLE and R_LOCK.
- R_IDLE: grant the round-robin pick combinationally.
  - Handshake with rlast: stay in R_IDLE, pointer := granted+1 (mod SLV_NB+1).
  - Granted valid without (handshake and rlast): register the grant, go to R_LOCK.
- R_LOCK: grant is held by the register, whatever the other requests are.
  - Handshake with rlast: go to R_IDLE, pointer := granted+1.
REQ-016 Bursts SHALL never interleave on i_rch.
- A granted valid that i_rready holds low SHALL keep its grant.
REQ-017 Outputs towards the master side:
- i_rvalid, i_rlast and i_rch SHALL reflect the granted requester.
- With no grant: i_rvalid=0, i_rlast=0, i_rch=0.
REQ-018 Outputs towards the slaves:
- o_rready[k] = i_rready & grant[k].
- Non-granted slaves SHALL see o_rready=0.
REQ-019 An AR handshake and an R handshake in the same cycle SHALL both take effect, including for the error generator.

Reset
REQ-020 With aresetn=0 at a rising edge of aclk, the block SHALL enter this state:
- R arbiter in R_IDLE, pointer=0, grant register=0.
- Error generator in ERR_IDLE, counter=0.
REQ-021 While aresetn=0, all outputs SHALL be held at:
- i_arready=0, o_arvalid=0, i_rvalid=0, i_rlast=0, o_rready=0.
REQ-022 Reset asserted in mid-burst SHALL abandon the lock and any pending error burst; nothing is resumed after reset.

Verification
REQ-023 Reset: hold aresetn=0 for 2 cycles with i_arvalid=1 and all o_rvalid=1 -> all outputs 0; after release, pointer=0 and the first R grant goes to slave 0.
REQ-024 Decode: i_arvalid=1 with ADDR=0x1010 -> o_arvalid=4'b0010, o_arch==i_arch; ADDR=0x0FFF -> 4'b0001; ADDR=0x3FFF -> 4'b1000.
REQ-025 Unmapped request:
- Stimulus: ADDR=0x8000, LEN=3, ID=0x05.
- Required: 4 R beats with RESP=2'b11, DATA=0, ID=0x05, and i_rlast only on beat 4.
- A second unmapped AR is held with i_arready=0 until beat 4 completes.
REQ-026 Burst lock:
- Stimulus: slaves 0 and 2 raise 4-beat bursts in the same cycle, pointer=0; i_rready is held low for 2 cycles after beat 2.
- Required: all 4 slave 0 beats complete, then all slave 2 beats; o_rready[2]=0 throughout the slave 0 burst.
REQ-027 Fairness: after slave 2 completes (pointer=3), slaves 0 and 2 request again -> slave 0 is granted first.
REQ-028 Reset in mid-burst: assert aresetn=0 after beat 2 of a slave 1 burst -> after release the arbiter is in R_IDLE and grants slave 0 first if slaves 0 and 1 both request.

Source files
------------

// File: rtl/axicb_slv_switch_rd.sv
// Read-path slave switch: decodes AR requests onto up to four slaves, answers
// unmapped reads with DECERR bursts and round-robin arbitrates returning R bursts.
module axicb_slv_switch_rd #(
    parameter int                    AXI_ADDR_W      = 16,
    parameter int                    AXI_ID_W        = 8,
    parameter int                    AXI_DATA_W      = 8,
    parameter int                    SLV_NB          = 4,
    parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = AXI_ADDR_W'('h0000),
    parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = AXI_ADDR_W'('h0FFF),
    parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = AXI_ADDR_W'('h1000),
    parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = AXI_ADDR_W'('h1FFF),
    parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = AXI_ADDR_W'('h2000),
    parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = AXI_ADDR_W'('h2FFF),
    parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = AXI_ADDR_W'('h3000),
    parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = AXI_ADDR_W'('h3FFF),
    parameter int                    ARCH_W          = AXI_ID_W + AXI_ADDR_W + 8,
    parameter int                    RCH_W           = AXI_ID_W + AXI_DATA_W + 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_arvalid,
    output logic                    i_arready,
    input  logic [ARCH_W-1:0]       i_arch,
    output logic                    i_rvalid,
    input  logic                    i_rready,
    output logic                    i_rlast,
    output logic [RCH_W-1:0]        i_rch,
    output logic [SLV_NB-1:0]       o_arvalid,
    input  logic [SLV_NB-1:0]       o_arready,
    output logic [ARCH_W-1:0]       o_arch,
    input  logic [SLV_NB-1:0]       o_rvalid,
    output logic [SLV_NB-1:0]       o_rready,
    input  logic [SLV_NB-1:0]       o_rlast,
    input  logic [SLV_NB*RCH_W-1:0] o_rch
);

    localparam int NREQ  = SLV_NB + 1;
    localparam int IDX_W = $clog2(NREQ);

    localparam logic [AXI_ADDR_W-1:0] START_ADDR [4] =
        '{SLV0_START_ADDR, SLV1_START_ADDR, SLV2_START_ADDR, SLV3_START_ADDR};
    localparam logic [AXI_ADDR_W-1:0] END_ADDR [4] =
        '{SLV0_END_ADDR, SLV1_END_ADDR, SLV2_END_ADDR, SLV3_END_ADDR};

    typedef enum logic {R_IDLE, R_LOCK} r_state_t;
    typedef enum logic {ERR_IDLE, ERR_RESP} err_state_t;

    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [7:0]            ar_len;
    logic [SLV_NB-1:0]     slv_hit;
    logic                  mapped;

    assign ar_addr = i_arch[AXI_ID_W +: AXI_ADDR_W];
    assign ar_id   = i_arch[0 +: AXI_ID_W];
    assign ar_len  = i_arch[AXI_ID_W+AXI_ADDR_W +: 8];
    assign o_arch  = i_arch;

    // First matching window wins, so overlapping maps resolve to the lowest index.
    always_comb begin
        slv_hit = '0;
        mapped  = 1'b0;
        for (int unsigned k = 0; k < SLV_NB; k++) begin
            if (!mapped && ar_addr >= START_ADDR[k] && ar_addr <= END_ADDR[k]) begin
                slv_hit[k] = 1'b1;
                mapped     = 1'b1;
            end
        end
    end

    err_state_t            err_state, err_state_nxt;
    logic [AXI_ID_W-1:0]   err_id, err_id_nxt;
    logic [7:0]            err_cnt, err_cnt_nxt;
    logic                  err_valid, err_last, ar_err_hs, err_hs;
    logic [RCH_W-1:0]      err_rch;

    assign err_valid = (err_state == ERR_RESP);
    assign err_last  = err_valid && (err_cnt == '0);
    assign ar_err_hs = i_arvalid && !mapped && (err_state == ERR_IDLE);
    assign o_arvalid = aresetn ? (slv_hit & {SLV_NB{i_arvalid}}) : '0;
    assign i_arready = aresetn && (mapped ? |(o_arready & slv_hit) : (err_state == ERR_IDLE));

    always_comb begin
        err_rch                 = '0;
        err_rch[RCH_W-2 +: 2]   = 2'b11;
        err_rch[0 +: AXI_ID_W]  = err_id;
    end

    r_state_t              r_state, r_state_nxt;
    logic [IDX_W-1:0]      ptr, ptr_nxt, lock_idx, lock_nxt, pick_idx, gnt_idx, ptr_wrap;
    logic                  pick_any, gnt_any, r_hs, r_done;
    logic [NREQ-1:0]       req, last_v, gnt_vec;
    logic [RCH_W-1:0]      rch_all [NREQ];
    int unsigned           slot;

    assign req    = {err_valid, o_rvalid};
    assign last_v = {err_last, o_rlast};

    always_comb begin
        for (int unsigned k = 0; k < SLV_NB; k++) rch_all[k] = o_rch[k*RCH_W +: RCH_W];
        rch_all[SLV_NB] = err_rch;
    end

    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        slot     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            slot = 32'(ptr) + i;
            if (slot >= NREQ) slot = slot - NREQ;
            if (!pick_any && req[slot]) begin
                pick_any = 1'b1;
                pick_idx = IDX_W'(slot);
            end
        end
    end

    always_comb begin
        gnt_any = pick_any;
        gnt_idx = pick_idx;
        if (r_state == R_LOCK) begin
            gnt_any = 1'b1;
            gnt_idx = lock_idx;
        end
    end

    assign gnt_vec  = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    assign i_rvalid = aresetn && gnt_any && req[gnt_idx];
    assign i_rlast  = aresetn && gnt_any && last_v[gnt_idx];
    assign i_rch    = (aresetn && gnt_any) ? rch_all[gnt_idx] : '0;
    assign o_rready = aresetn ? (gnt_vec[SLV_NB-1:0] & {SLV_NB{i_rready}}) : '0;
    assign r_hs     = i_rvalid && i_rready;
    assign r_done   = r_hs && i_rlast;
    assign err_hs   = r_hs && gnt_vec[SLV_NB];
    assign ptr_wrap = (gnt_idx == IDX_W'(SLV_NB)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        r_state_nxt = r_state;
        ptr_nxt     = ptr;
        lock_nxt    = lock_idx;
        case (r_state)
            R_IDLE: begin
                if (r_done) begin
                    ptr_nxt = ptr_wrap;
                end else if (i_rvalid) begin
                    r_state_nxt = R_LOCK;
                    lock_nxt    = gnt_idx;
                end
            end
            R_LOCK: begin
                if (r_done) begin
                    r_state_nxt = R_IDLE;
                    ptr_nxt     = ptr_wrap;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        err_state_nxt = err_state;
        err_id_nxt    = err_id;
        err_cnt_nxt   = err_cnt;
        case (err_state)
            ERR_IDLE: begin
                if (ar_err_hs) begin
                    err_state_nxt = ERR_RESP;
                    err_id_nxt    = ar_id;
                    err_cnt_nxt   = ar_len;
                end
            end
            ERR_RESP: begin
                if (err_hs) begin
                    if (err_cnt == '0) err_state_nxt = ERR_IDLE;
                    else               err_cnt_nxt   = err_cnt - 1'b1;
                end
            end
            default: err_state_nxt = ERR_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            ptr       <= '0;
            lock_idx  <= '0;
            err_state <= ERR_IDLE;
            err_id    <= '0;
            err_cnt   <= '0;
        end else begin
            r_state   <= r_state_nxt;
            ptr       <= ptr_nxt;
            lock_idx  <= lock_nxt;
            err_state <= err_state_nxt;
            err_id    <= err_id_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_axicb_slv_switch_rd.sv
// Bench for axicb_slv_switch_rd: directed scenarios with literal expectations,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_axicb_slv_switch_rd;

    localparam int NS     = 4;
    localparam int ARCH_W = 32;
    localparam int RCH_W  = 18;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 i_arvalid = 1'b0;
    logic                 i_arready;
    logic [ARCH_W-1:0]    i_arch = '0;
    logic                 i_rvalid;
    logic                 i_rready = 1'b0;
    logic                 i_rlast;
    logic [RCH_W-1:0]     i_rch;
    logic [NS-1:0]        o_arvalid;
    logic [NS-1:0]        o_arready = '0;
    logic [ARCH_W-1:0]    o_arch;
    logic [NS-1:0]        o_rvalid = '0;
    logic [NS-1:0]        o_rready;
    logic [NS-1:0]        o_rlast = '0;
    logic [NS*RCH_W-1:0]  o_rch = '0;

    axicb_slv_switch_rd #(
        .AXI_ADDR_W (16),
        .AXI_ID_W   (8),
        .AXI_DATA_W (8),
        .SLV_NB     (NS)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_arch    (i_arch),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .i_rlast   (i_rlast),
        .i_rch     (i_rch),
        .o_arvalid (o_arvalid),
        .o_arready (o_arready),
        .o_arch    (o_arch),
        .o_rvalid  (o_rvalid),
        .o_rready  (o_rready),
        .o_rlast   (o_rlast),
        .o_rch     (o_rch)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state: who owns the R channel (-1 = nobody), the
    // round-robin start point and the pending DECERR burst.
    int         m_owner = -1;
    int         m_ptr = 0;
    bit         m_err = 0;
    logic [7:0] m_err_id = '0;
    int         m_err_left = 0;

    int               e_g, e_tgt;
    logic             e_arready, e_rvalid, e_rlast;
    logic [NS-1:0]    e_arvalid, e_rready;
    logic [RCH_W-1:0] e_rch;

    logic             c_arready, c_rvalid, c_rlast;
    logic [NS-1:0]    c_arvalid, c_rready;
    logic [RCH_W-1:0] c_rch;
    logic [ARCH_W-1:0] c_arch;

    // Slave source models
    bit bfm_rand = 0;
    int rem [NS];
    bit fresh [NS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit req_of(input int j);
        return (j < NS) ? bit'(o_rvalid[j]) : m_err;
    endfunction

    task automatic model_eval();
        logic [15:0] addr;
        addr = i_arch[23:8];
        e_tgt = (addr < 16'h4000) ? int'(addr >> 12) : -1;
        if (m_owner >= 0) e_g = m_owner;
        else begin
            e_g = -1;
            for (int i = 0; i < NS + 1; i++) begin
                int j;
                j = (m_ptr + i) % (NS + 1);
                if (e_g < 0 && req_of(j)) e_g = j;
            end
        end
        e_arvalid = '0; e_arready = 0; e_rvalid = 0; e_rlast = 0; e_rready = '0; e_rch = '0;
        if (aresetn) begin
            if (e_tgt >= 0) begin
                e_arvalid = i_arvalid ? NS'(1 << e_tgt) : '0;
                e_arready = o_arready[e_tgt];
            end else begin
                e_arready = !m_err;
            end
            if (e_g == NS) begin
                e_rvalid = m_err;
                e_rlast  = m_err && (m_err_left == 1);
                e_rch    = {2'b11, 8'h00, m_err_id};
            end else if (e_g >= 0) begin
                e_rvalid = o_rvalid[e_g];
                e_rlast  = o_rlast[e_g];
                e_rch    = o_rch[e_g*RCH_W +: RCH_W];
                e_rready = i_rready ? NS'(1 << e_g) : '0;
            end
        end
    endtask

    task automatic model_update();
        bit ar_err, rhs;
        if (!aresetn) begin
            m_owner = -1; m_ptr = 0; m_err = 0; m_err_left = 0;
        end else begin
            ar_err = i_arvalid && (e_tgt < 0) && !m_err;
            rhs    = e_rvalid && i_rready;
            if (rhs && e_rlast) begin
                m_owner = -1;
                m_ptr   = (e_g + 1) % (NS + 1);
            end else if (e_rvalid) begin
                m_owner = e_g;
            end
            if (rhs && e_g == NS) begin
                if (m_err_left == 1) m_err = 0;
                else m_err_left--;
            end
            if (ar_err) begin
                m_err      = 1;
                m_err_id   = i_arch[7:0];
                m_err_left = int'(i_arch[31:24]) + 1;
            end
        end
    endtask

    task automatic bfm_consume();
        for (int k = 0; k < NS; k++) begin
            if (c_rready[k] && o_rvalid[k]) begin
                rem[k]--;
                fresh[k] = 1;
            end
            if (bfm_rand && rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 4);
        end
    endtask

    task automatic bfm_drive();
        for (int k = 0; k < NS; k++) begin
            if (rem[k] == 0) begin
                o_rvalid[k] = 1'b0;
            end else if (!(o_rvalid[k] && !fresh[k])) begin
                o_rvalid[k] = bfm_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                o_rch[k*RCH_W +: RCH_W] = {2'($urandom_range(0, 3)), 8'($urandom), 8'(k)};
            end
            o_rlast[k] = (rem[k] == 1);
            fresh[k] = 0;
        end
    endtask

    // The single per-cycle compare point, half a cycle after inputs settle.
    task automatic tick();
        @(negedge aclk);
        model_eval();
        chk("arready", i_arready, e_arready);
        chk("arvalid", o_arvalid, e_arvalid);
        chk("arch", o_arch, i_arch);
        chk("rvalid", i_rvalid, e_rvalid);
        chk("rlast", i_rlast, e_rlast);
        chk("rready", o_rready, e_rready);
        if (aresetn) chk("rch", i_rch, e_rch);
        c_arready = i_arready; c_arvalid = o_arvalid; c_arch = o_arch;
        c_rvalid = i_rvalid; c_rlast = i_rlast; c_rch = i_rch; c_rready = o_rready;
        @(posedge aclk);
        #1;
        model_update();
        bfm_consume();
        bfm_drive();
    endtask

    initial begin
        logic [15:0] dec_addr [3];
        logic [3:0]  dec_exp [3];
        int nb;
        dec_addr = '{16'h1010, 16'h0FFF, 16'h3FFF};
        dec_exp  = '{4'b0010, 4'b0001, 4'b1000};
        for (int k = 0; k < NS; k++) begin rem[k] = 1; fresh[k] = 0; end

        // Reset with every requester active.
        aresetn = 0; i_arvalid = 1; i_arch = {8'd0, 16'h1010, 8'h11};
        o_arready = '1; i_rready = 1;
        bfm_drive();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out", {c_arready, c_arvalid, c_rvalid, c_rlast, c_rready}, '0);
        end
        aresetn = 1; i_arvalid = 0;
        for (int k = 0; k < NS; k++) begin
            tick();
            chk("rst_rr_order", c_rready, 64'(1 << k));
        end

        // Decode windows.
        i_rready = 0; i_arvalid = 1; o_arready = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            i_arch = {8'd2, dec_addr[i], 8'h33};
            tick();
            chk("dec_arvalid", c_arvalid, dec_exp[i]);
            chk("dec_arch", c_arch, {8'd2, dec_addr[i], 8'h33});
            chk("dec_arready", c_arready, i == 0);
        end

        // Unmapped request, second one held off until the DECERR burst ends.
        i_rready = 1; i_arch = {8'd3, 16'h8000, 8'h05};
        tick();
        chk("unm_accept", c_arready, 1);
        i_arch = {8'd0, 16'h9000, 8'h06};
        for (int b = 1; b <= 4; b++) begin
            tick();
            chk("unm_hold", c_arready, 0);
            chk("unm_beat", {c_rvalid, c_rlast, c_rch}, {1'b1, b == 4, 18'h30005});
        end
        tick();
        chk("unm_second", {c_arready, c_rvalid}, 2'b10);
        i_arvalid = 0;
        tick();
        chk("unm_second_beat", {c_rvalid, c_rlast, c_rch}, {2'b11, 18'h30006});

        // Burst lock with a stall after beat 2.
        rem[0] = 4; rem[2] = 4; bfm_drive();
        nb = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            i_rready = (cyc != 2 && cyc != 3);
            tick();
            if (i_rready) begin
                chk("lock_gnt", c_rready, (nb < 4) ? 4'b0001 : 4'b0100);
                chk("lock_last", c_rlast, nb == 3 || nb == 7);
                nb++;
            end else begin
                chk("lock_stall", {c_rvalid, c_rready, c_rch[7:0]}, {1'b1, 4'b0000, 8'h00});
            end
        end

        // Fairness after slave 2 finished.
        i_rready = 1; rem[0] = 1; rem[2] = 1; bfm_drive();
        tick(); chk("fair_first", c_rready, 4'b0001);
        tick(); chk("fair_second", c_rready, 4'b0100);

        // Reset in the middle of a slave 1 burst.
        rem[1] = 4; bfm_drive();
        tick(); chk("mid_b1", c_rready, 4'b0010);
        tick(); chk("mid_b2", c_rready, 4'b0010);
        aresetn = 0;
        tick(); chk("mid_rst", {c_rvalid, c_rready}, '0);
        aresetn = 1; rem[0] = 1; bfm_drive();
        tick(); chk("mid_after", c_rready, 4'b0001);
        tick(); chk("mid_resume", c_rready, 4'b0010);

        // Randomized traffic.
        bfm_rand = 1;
        for (int n = 0; n < 3000; n++) begin
            int hi;
            hi = $urandom_range(0, 5);
            aresetn   = ($urandom_range(0, 63) != 0);
            i_arvalid = $urandom_range(0, 1) != 0;
            i_arch    = {8'($urandom_range(0, 3)), 16'(hi << 12) | 16'($urandom_range(0, 4095)), 8'($urandom)};
            o_arready = 4'($urandom);
            i_rready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
